// File: rtl/vote_argmax_classifier_pkg.sv
// Shared definitions for the vote argmax classifier: default sizing and FSM state encoding.
package vote_argmax_classifier_pkg;

   localparam int OUTPUT_DIM_DEFAULT       = 10;
   localparam int W_BITLENGTH_DEFAULT      = 12;
   localparam int IDX_BITLENGTH_DEFAULT    = 4;
   localparam int MARGIN_THRESHOLD_DEFAULT = 8;
   localparam int STAT_BITLENGTH_DEFAULT   = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SCAN = 2'd2,
      S_HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/vote_argmax_classifier_compare_step.sv
// One step of the running argmax: folds a single class count into the best/second-best tracker.
module vote_compare_step
   import vote_argmax_classifier_pkg::*;
#(
   parameter int w_bitlength   = W_BITLENGTH_DEFAULT,
   parameter int idx_bitlength = IDX_BITLENGTH_DEFAULT
) (
   input  logic [w_bitlength-1:0]   v,
   input  logic [idx_bitlength-1:0] idx,
   input  logic [w_bitlength-1:0]   best,
   input  logic [idx_bitlength-1:0] best_idx,
   input  logic [w_bitlength-1:0]   second,
   output logic [w_bitlength-1:0]   best_next,
   output logic [idx_bitlength-1:0] best_idx_next,
   output logic [w_bitlength-1:0]   second_next
);

   // Strict compares so an equal count never displaces the earlier (lower) index.
   always_comb begin
      best_next     = best;
      best_idx_next = best_idx;
      second_next   = second;
      if (v > best) begin
         second_next   = best;
         best_next     = v;
         best_idx_next = idx;
      end else if (v > second) begin
         second_next = v;
      end
   end

endmodule

// File: rtl/vote_argmax_classifier.sv
// Sequential argmax over per-class vote counters with a valid/ready result port
// and saturating hit/sample statistics against a supplied label.
module vote_argmax_classifier
   import vote_argmax_classifier_pkg::*;
#(
   parameter int output_dim       = OUTPUT_DIM_DEFAULT,
   parameter int w_bitlength      = W_BITLENGTH_DEFAULT,
   parameter int idx_bitlength    = IDX_BITLENGTH_DEFAULT,
   parameter int margin_threshold = MARGIN_THRESHOLD_DEFAULT,
   parameter int stat_bitlength   = STAT_BITLENGTH_DEFAULT
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              finish,
   input  logic [output_dim*w_bitlength-1:0] VoteData,
   input  logic [idx_bitlength-1:0]          label,
   input  logic                              result_ready,
   output logic                              result_valid,
   output logic [idx_bitlength-1:0]          class_out,
   output logic [w_bitlength-1:0]            top_count,
   output logic [w_bitlength-1:0]            margin,
   output logic                              ambiguous,
   output logic                              busy,
   output logic                              overrun,
   output logic [stat_bitlength-1:0]         hit_count,
   output logic [stat_bitlength-1:0]         sample_count
);

   state_t                   state;
   logic                     finish_d;
   logic                     start;
   logic                     last_class;
   logic [w_bitlength-1:0]   votes_q [output_dim];
   logic [idx_bitlength-1:0] label_q;
   logic [idx_bitlength-1:0] idx;
   logic [w_bitlength-1:0]   best;
   logic [idx_bitlength-1:0] best_idx;
   logic [w_bitlength-1:0]   second;
   logic [w_bitlength-1:0]   best_nx;
   logic [idx_bitlength-1:0] best_idx_nx;
   logic [w_bitlength-1:0]   second_nx;
   logic [w_bitlength-1:0]   margin_nx;

   assign start      = finish & ~finish_d;
   assign busy       = (state != S_IDLE);
   assign last_class = (idx == idx_bitlength'(output_dim - 1));
   assign margin_nx  = best_nx - second_nx;

   vote_compare_step #(
      .w_bitlength   (w_bitlength),
      .idx_bitlength (idx_bitlength)
   ) u_step (
      .v             (votes_q[idx]),
      .idx           (idx),
      .best          (best),
      .best_idx      (best_idx),
      .second        (second),
      .best_next     (best_nx),
      .best_idx_next (best_idx_nx),
      .second_next   (second_nx)
   );

   // The result fields are loaded from the step outputs on the last SCAN cycle,
   // so the final class is folded in without an extra cycle before HOLD.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         finish_d     <= 1'b0;
         label_q      <= '0;
         idx          <= '0;
         best         <= '0;
         best_idx     <= '0;
         second       <= '0;
         result_valid <= 1'b0;
         class_out    <= '0;
         top_count    <= '0;
         margin       <= '0;
         ambiguous    <= 1'b0;
         overrun      <= 1'b0;
         hit_count    <= '0;
         sample_count <= '0;
         for (int i = 0; i < output_dim; i++) begin
            votes_q[i] <= '0;
         end
      end else begin
         finish_d <= finish;
         if (start && (state != S_IDLE)) begin
            overrun <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < output_dim; i++) begin
                     votes_q[i] <= VoteData[i*w_bitlength +: w_bitlength];
                  end
                  label_q <= label;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               idx      <= '0;
               best     <= '0;
               best_idx <= '0;
               second   <= '0;
               state    <= S_SCAN;
            end
            S_SCAN: begin
               best     <= best_nx;
               best_idx <= best_idx_nx;
               second   <= second_nx;
               if (last_class) begin
                  class_out    <= best_idx_nx;
                  top_count    <= best_nx;
                  margin       <= margin_nx;
                  ambiguous    <= (margin_nx < w_bitlength'(margin_threshold));
                  result_valid <= 1'b1;
                  if (sample_count != '1) begin
                     sample_count <= sample_count + 1'b1;
                  end
                  if ((best_idx_nx == label_q) && (hit_count != '1)) begin
                     hit_count <= hit_count + 1'b1;
                  end
                  state <= S_HOLD;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_HOLD: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vote_argmax_classifier.sv
// Directed bench for vote_argmax_classifier: a 10-class instance for function and
// handshake, and a 1-class, 4-bit-statistics instance for margin and saturation.
module tb_vote_argmax_classifier;

   logic         clock;
   logic         reset;
   logic         finish;
   logic [119:0] VoteData;
   logic [3:0]   label;
   logic         result_ready;
   logic         result_valid;
   logic [3:0]   class_out;
   logic [11:0]  top_count;
   logic [11:0]  margin;
   logic         ambiguous;
   logic         busy;
   logic         overrun;
   logic [15:0]  hit_count;
   logic [15:0]  sample_count;

   logic         finish2;
   logic [11:0]  vote_data2;
   logic [0:0]   label2;
   logic         ready2;
   logic         valid2;
   logic [0:0]   class2;
   logic [11:0]  top2;
   logic [11:0]  margin2;
   logic         ambiguous2;
   logic         busy2;
   logic         overrun2;
   logic [3:0]   hit2;
   logic [3:0]   sample2;

   int checks;
   int errors;

   vote_argmax_classifier #(
      .output_dim(10), .w_bitlength(12), .idx_bitlength(4),
      .margin_threshold(8), .stat_bitlength(16)
   ) dut (
      .clock(clock), .reset(reset), .finish(finish), .VoteData(VoteData),
      .label(label), .result_ready(result_ready), .result_valid(result_valid),
      .class_out(class_out), .top_count(top_count), .margin(margin),
      .ambiguous(ambiguous), .busy(busy), .overrun(overrun),
      .hit_count(hit_count), .sample_count(sample_count)
   );

   vote_argmax_classifier #(
      .output_dim(1), .w_bitlength(12), .idx_bitlength(1),
      .margin_threshold(8), .stat_bitlength(4)
   ) dut2 (
      .clock(clock), .reset(reset), .finish(finish2), .VoteData(vote_data2),
      .label(label2), .result_ready(ready2), .result_valid(valid2),
      .class_out(class2), .top_count(top2), .margin(margin2),
      .ambiguous(ambiguous2), .busy(busy2), .overrun(overrun2),
      .hit_count(hit2), .sample_count(sample2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [119:0] pack10(input int c0, input int c1, input int c2,
                                           input int c3, input int c4, input int c5,
                                           input int c6, input int c7, input int c8,
                                           input int c9);
      pack10 = {12'(c9), 12'(c8), 12'(c7), 12'(c6), 12'(c5),
                12'(c4), 12'(c3), 12'(c2), 12'(c1), 12'(c0)};
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset        = 1'b0;
      finish       = 1'b0;
      result_ready = 1'b0;
      finish2      = 1'b0;
      ready2       = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   // Raises finish at the current negedge, drops it and scrambles the inputs one
   // cycle later, optionally pulses finish again, and waits for result_valid.
   task automatic send(input logic [119:0] votes, input logic [3:0] lbl,
                       input int pulse_at, output int lat);
      finish   = 1'b1;
      VoteData = votes;
      label    = lbl;
      lat      = 0;
      while (lat < 40) begin
         @(negedge clock);
         lat++;
         if (lat == 1) begin
            finish   = 1'b0;
            VoteData = '1;
            label    = ~lbl;
         end
         if (pulse_at != 0 && lat == pulse_at) finish = 1'b1;
         if (pulse_at != 0 && lat == pulse_at + 1) finish = 1'b0;
         if (result_valid) break;
      end
      checks++;
      if (result_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL valid_timeout: result_valid=%b after %0d cycles, expected 1", result_valid, lat);
      end
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      reset        = 1'b0;
      finish       = 1'b0;
      VoteData     = '0;
      label        = '0;
      result_ready = 1'b0;
      finish2      = 1'b0;
      vote_data2   = '0;
      label2       = '0;
      ready2       = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({result_valid, class_out, top_count, margin, ambiguous, busy, overrun} !== 31'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got v=%b c=%0d t=%0d m=%0d a=%b b=%b o=%b, expected all 0",
                  result_valid, class_out, top_count, margin, ambiguous, busy, overrun);
      end
      checks++;
      if ({hit_count, sample_count} !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_stats: got hit=%0d sample=%0d, expected 0 0", hit_count, sample_count);
      end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int lat;
      $display("[TB] test_basic");
      result_ready = 1'b1;
      send(pack10(3, 9, 1, 0, 0, 0, 0, 0, 0, 40), 4'd9, 0, lat);
      checks++;
      if (lat !== 12) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d cycles, expected 12", lat);
      end
      checks++;
      if ({class_out, top_count, margin, ambiguous} !== {4'd9, 12'd40, 12'd31, 1'b0}) begin
         errors++;
         $display("[TB] FAIL basic_result: got c=%0d t=%0d m=%0d a=%b, expected c=9 t=40 m=31 a=0",
                  class_out, top_count, margin, ambiguous);
      end
      checks++;
      if ({hit_count, sample_count, busy} !== {16'd1, 16'd1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL basic_stats: got hit=%0d sample=%0d busy=%b, expected 1 1 1",
                  hit_count, sample_count, busy);
      end
      @(negedge clock);
      checks++;
      if ({result_valid, busy, class_out} !== {1'b0, 1'b0, 4'd9}) begin
         errors++;
         $display("[TB] FAIL basic_after_handshake: got v=%b b=%b c=%0d, expected v=0 b=0 c=9",
                  result_valid, busy, class_out);
      end
   endtask

   task automatic test_tie();
      int lat;
      $display("[TB] test_tie");
      send(pack10(0, 25, 0, 0, 25, 0, 0, 0, 0, 0), 4'd4, 0, lat);
      checks++;
      if ({class_out, top_count, margin, ambiguous} !== {4'd1, 12'd25, 12'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL tie_result: got c=%0d t=%0d m=%0d a=%b, expected c=1 t=25 m=0 a=1",
                  class_out, top_count, margin, ambiguous);
      end
      checks++;
      if ({hit_count, sample_count} !== {16'd1, 16'd2}) begin
         errors++;
         $display("[TB] FAIL tie_stats: got hit=%0d sample=%0d, expected 1 2", hit_count, sample_count);
      end
      @(negedge clock);
   endtask

   task automatic test_zero();
      int lat;
      $display("[TB] test_zero");
      send(pack10(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4'd3, 0, lat);
      checks++;
      if ({class_out, top_count, margin, ambiguous} !== {4'd0, 12'd0, 12'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL zero_result: got c=%0d t=%0d m=%0d a=%b, expected c=0 t=0 m=0 a=1",
                  class_out, top_count, margin, ambiguous);
      end
      checks++;
      if ({hit_count, sample_count} !== {16'd1, 16'd3}) begin
         errors++;
         $display("[TB] FAIL zero_stats: got hit=%0d sample=%0d, expected 1 3", hit_count, sample_count);
      end
      @(negedge clock);
   endtask

   task automatic test_hold_stall();
      int lat;
      int bad;
      $display("[TB] test_hold_stall");
      result_ready = 1'b0;
      send(pack10(10, 2, 30, 0, 0, 0, 0, 0, 18, 0), 4'd2, 0, lat);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if ({result_valid, class_out, top_count, margin, ambiguous} !== {1'b1, 4'd2, 12'd30, 12'd12, 1'b0})
            bad++;
         @(negedge clock);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL stall_stable: %0d unstable cycles, now v=%b c=%0d t=%0d m=%0d a=%b, expected v=1 c=2 t=30 m=12 a=0",
                  bad, result_valid, class_out, top_count, margin, ambiguous);
      end
      checks++;
      if ({hit_count, sample_count} !== {16'd2, 16'd4}) begin
         errors++;
         $display("[TB] FAIL stall_stats: got hit=%0d sample=%0d, expected 2 4", hit_count, sample_count);
      end
      result_ready = 1'b1;
      @(negedge clock);
      checks++;
      if ({result_valid, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL stall_release: got v=%b b=%b, expected 0 0", result_valid, busy);
      end
   endtask

   task automatic test_reset_mid_scan();
      $display("[TB] test_reset_mid_scan");
      result_ready = 1'b1;
      finish   = 1'b1;
      VoteData = pack10(1, 1, 1, 1, 1, 1, 1, 1, 1, 50);
      label    = 4'd9;
      @(negedge clock);
      finish = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({result_valid, class_out, top_count, margin, ambiguous, busy, overrun,
           hit_count, sample_count} !== 63'd0) begin
         errors++;
         $display("[TB] FAIL midscan_reset: got v=%b c=%0d t=%0d m=%0d a=%b b=%b o=%b hit=%0d sample=%0d, expected all 0",
                  result_valid, class_out, top_count, margin, ambiguous, busy, overrun, hit_count, sample_count);
      end
      @(negedge clock);
      reset = 1'b1;
      repeat (14) @(negedge clock);
      checks++;
      if ({result_valid, busy, sample_count} !== {1'b0, 1'b0, 16'd0}) begin
         errors++;
         $display("[TB] FAIL midscan_idle: got v=%b b=%b sample=%0d, expected 0 0 0",
                  result_valid, busy, sample_count);
      end
   endtask

   task automatic test_overrun();
      int lat;
      $display("[TB] test_overrun");
      do_reset();
      send(pack10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10), 4'd9, 5, lat);
      checks++;
      if ({overrun, lat[4:0]} !== {1'b1, 5'd12}) begin
         errors++;
         $display("[TB] FAIL overrun_scan: got overrun=%b latency=%0d, expected 1 12", overrun, lat);
      end
      finish = 1'b1;
      @(negedge clock);
      finish = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({result_valid, class_out, top_count, margin, ambiguous} !== {1'b1, 4'd9, 12'd10, 12'd1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL overrun_result: got v=%b c=%0d t=%0d m=%0d a=%b, expected v=1 c=9 t=10 m=1 a=1",
                  result_valid, class_out, top_count, margin, ambiguous);
      end
      checks++;
      if ({overrun, hit_count, sample_count} !== {1'b1, 16'd1, 16'd1}) begin
         errors++;
         $display("[TB] FAIL overrun_stats: got o=%b hit=%0d sample=%0d, expected 1 1 1",
                  overrun, hit_count, sample_count);
      end
      result_ready = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({result_valid, busy, sample_count} !== {1'b0, 1'b0, 16'd1}) begin
         errors++;
         $display("[TB] FAIL overrun_idle: got v=%b b=%b sample=%0d, expected 0 0 1",
                  result_valid, busy, sample_count);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      $display("[TB] test_back_to_back");
      do_reset();
      send(pack10(0, 0, 0, 0, 0, 0, 20, 0, 0, 0), 4'd6, 0, lat);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_no_overrun: got overrun=%b, expected 0", overrun);
      end
      result_ready = 1'b1;
      finish       = 1'b1;
      @(negedge clock);
      finish = 1'b0;
      checks++;
      if ({result_valid, busy, overrun} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL b2b_handshake_start: got v=%b b=%b o=%b, expected 0 0 1",
                  result_valid, busy, overrun);
      end
      repeat (2) @(negedge clock);
      checks++;
      if ({busy, sample_count, hit_count} !== {1'b0, 16'd1, 16'd1}) begin
         errors++;
         $display("[TB] FAIL b2b_dropped: got b=%b sample=%0d hit=%0d, expected 0 1 1",
                  busy, sample_count, hit_count);
      end
      send(pack10(0, 0, 9, 0, 0, 0, 0, 0, 0, 0), 4'd5, 0, lat);
      checks++;
      if ({class_out, top_count, margin, ambiguous, sample_count, hit_count} !==
          {4'd2, 12'd9, 12'd9, 1'b0, 16'd2, 16'd1}) begin
         errors++;
         $display("[TB] FAIL b2b_second: got c=%0d t=%0d m=%0d a=%b sample=%0d hit=%0d, expected c=2 t=9 m=9 a=0 sample=2 hit=1",
                  class_out, top_count, margin, ambiguous, sample_count, hit_count);
      end
      @(negedge clock);
   endtask

   task automatic test_saturation();
      int lat;
      $display("[TB] test_saturation");
      ready2     = 1'b1;
      vote_data2 = 12'd7;
      label2     = 1'b0;
      for (int n = 0; n < 18; n++) begin
         finish2 = 1'b1;
         lat     = 0;
         while (lat < 10) begin
            @(negedge clock);
            lat++;
            finish2 = 1'b0;
            if (valid2) break;
         end
         if (n == 0) begin
            checks++;
            if ({valid2, lat[3:0], class2, top2, margin2, ambiguous2} !==
                {1'b1, 4'd3, 1'b0, 12'd7, 12'd7, 1'b1}) begin
               errors++;
               $display("[TB] FAIL single_class: got v=%b lat=%0d c=%0d t=%0d m=%0d a=%b, expected v=1 lat=3 c=0 t=7 m=7 a=1",
                        valid2, lat, class2, top2, margin2, ambiguous2);
            end
         end
         if (n == 9) begin
            checks++;
            if ({sample2, hit2} !== {4'd10, 4'd10}) begin
               errors++;
               $display("[TB] FAIL sat_mid: got sample=%0d hit=%0d, expected 10 10", sample2, hit2);
            end
         end
         @(negedge clock);
      end
      checks++;
      if ({sample2, hit2, busy2, overrun2} !== {4'hF, 4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL sat_final: got sample=%0d hit=%0d b=%b o=%b, expected 15 15 0 0",
                  sample2, hit2, busy2, overrun2);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_tie();
      test_zero();
      test_hold_stall();
      test_reset_mid_scan();
      test_overrun();
      test_back_to_back();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
